// File: rtl/adc_scan_scheduler_pkg.sv
// Shared types and constants for the ADC scan scheduler.
package adc_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PICK  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Index of the lowest set bit of mask; 0 when the mask is empty.
    function automatic logic [ADDR_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = ADDR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/adc_scan_scheduler_period_tick.sv
// Free-running down-counter producing a one-cycle tick every PERIOD_CYC clocks.
// The first tick lands PERIOD_CYC cycles after reset is released.
module period_tick #(
    parameter int PERIOD_CYC = 12000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    logic [CNT_W-1:0] r_count;

    // Count down to zero, reloading on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= CNT_W'(PERIOD_CYC - 1);
        end else if (r_count == '0) begin
            r_count <= CNT_W'(PERIOD_CYC - 1);
        end else begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign tick = (r_count == '0);

endmodule

// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC scan scheduler. Each period tick snapshots the enable mask
// and requests one conversion per enabled channel in ascending order, storing
// the samples in a per-channel result bank with a registered read port.
//
// Handshake: conv_start is a single-cycle request; conv_addr is stable from
// conv_start until the matching conv_done pulse (which carries conv_data in
// the same cycle) or until the wait counter expires. conv_done is only
// honoured while waiting; pulses at any other time are dropped.
module adc_scan_scheduler
    import adc_scan_pkg::*;
#(
    parameter int PERIOD_CYC  = 12000,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] chan_en,
    output logic              conv_start,
    output logic [ADDR_W-1:0] conv_addr,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              scan_done,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_CH-1:0]   r_pend;
    logic [ADDR_W-1:0]   r_conv_addr;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [DATA_W-1:0]   r_bank [NUM_CH];
    logic [NUM_CH-1:0]   r_valid;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_scan_done;
    logic                r_timeout_err;
    logic                r_overrun_err;

    logic                w_tick;
    logic                w_start_round;
    logic                w_done;
    logic                w_timeout;
    logic                w_finish;
    logic                w_last;
    logic [NUM_CH-1:0]   w_ch_mask;

    period_tick #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_period_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // A round only starts from IDLE with at least one channel enabled.
    assign w_start_round = (r_state == IDLE) && w_tick && (chan_en != '0);
    // A done pulse in the final wait cycle beats the timeout.
    assign w_done        = (r_state == WAIT) && conv_done;
    assign w_timeout     = (r_state == WAIT) && !conv_done &&
                           (r_wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
    assign w_finish      = w_done || w_timeout;
    assign w_ch_mask     = NUM_CH'(1) << r_conv_addr;
    assign w_last        = ((r_pend & ~w_ch_mask) == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_round) w_state_next = PICK;
            PICK:    w_state_next = START;
            START:   w_state_next = WAIT;
            WAIT:    if (w_finish) w_state_next = w_last ? IDLE : PICK;
            default: w_state_next = IDLE;
        endcase
    end

    // Round bookkeeping, wait counter and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend        <= '0;
            r_conv_addr   <= '0;
            r_wait_cnt    <= '0;
            r_scan_done   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (w_start_round) begin
                r_pend <= chan_en;
            end
            if (r_state == PICK) begin
                r_conv_addr <= lowest_set(r_pend);
            end
            if (r_state == START) begin
                r_wait_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_finish) begin
                r_pend <= r_pend & ~w_ch_mask;
                if (w_last) begin
                    r_scan_done <= 1'b1;
                end
            end
            // A tick that arrives mid-round is dropped, only flagged.
            if (w_tick && (r_state != IDLE)) begin
                r_overrun_err <= 1'b1;
            end
        end
    end

    // Result bank: sample and valid bit per channel; a timeout keeps old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_bank[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            if (w_done) begin
                r_bank[r_conv_addr]  <= conv_data;
                r_valid[r_conv_addr] <= 1'b1;
            end else if (w_timeout) begin
                r_valid[r_conv_addr] <= 1'b0;
            end
        end
    end

    // Registered read port; a same-cycle write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_data  <= r_bank[rd_addr];
            r_rd_valid <= r_valid[rd_addr];
        end
    end

    // The request is masked during reset so an interrupted START never leaks out.
    assign conv_start  = (r_state == START) && !reset;
    assign conv_addr   = r_conv_addr;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign scan_done   = r_scan_done;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeout_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: directed scenarios plus a randomized phase,
// checked every cycle against a timestamp-based reference model.
module tb_adc_scan_scheduler;

    localparam int P   = 100;
    localparam int TMO = 16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  chan_en;
    logic        conv_start;
    logic [2:0]  conv_addr;
    logic        conv_done;
    logic [11:0] conv_data;
    logic [2:0]  rd_addr;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        scan_done;
    logic        busy;
    logic        timeout_err;
    logic        overrun_err;

    always #5 clk = ~clk;

    adc_scan_scheduler #(
        .PERIOD_CYC  (P),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chan_en     (chan_en),
        .conv_start  (conv_start),
        .conv_addr   (conv_addr),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .scan_done   (scan_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Timestamp view: a round is a queue of channels; each conversion has a
    // start cycle, a done window of TMO cycles after it, and the next start
    // follows two cycles after the conversion ends.
    int          m_cyc;
    int          m_start_at;
    int          m_done_at;
    int          m_ch;
    int          m_q[$];
    bit          m_busy;
    bit          m_terr;
    bit          m_oerr;
    logic [11:0] m_bank[8];
    bit          m_valid[8];
    logic [11:0] m_rd_data;
    bit          m_rd_valid;
    logic [2:0]  m_addr;

    logic        exp_start;
    logic [2:0]  exp_addr;
    logic        exp_busy;
    logic        exp_scan;
    logic        exp_terr;
    logic        exp_oerr;
    logic [11:0] exp_rdata;
    logic        exp_rvalid;
    bit          chk_on = 0;

    task automatic model_reset();
        m_cyc      = 0;
        m_start_at = -1;
        m_done_at  = -1;
        m_ch       = 0;
        m_q.delete();
        m_busy     = 0;
        m_terr     = 0;
        m_oerr     = 0;
        m_addr     = 3'd0;
        m_rd_data  = 12'd0;
        m_rd_valid = 0;
        for (int i = 0; i < 8; i++) begin
            m_bank[i]  = 12'd0;
            m_valid[i] = 0;
        end
    endtask

    task automatic model_outputs();
        if (m_start_at == m_cyc) m_addr = 3'(m_ch);
        exp_start  = (m_start_at == m_cyc) && !reset;
        exp_addr   = m_addr;
        exp_busy   = m_busy;
        exp_scan   = (m_done_at == m_cyc);
        exp_terr   = m_terr;
        exp_oerr   = m_oerr;
        exp_rdata  = m_rd_data;
        exp_rvalid = m_rd_valid;
    endtask

    task automatic model_update();
        bit nb;
        bit fin;
        if (reset) begin
            model_reset();
            return;
        end
        nb = m_busy;
        m_rd_data  = m_bank[rd_addr];
        m_rd_valid = m_valid[rd_addr];
        if (m_busy && m_start_at >= 0 && m_cyc > m_start_at && m_cyc <= m_start_at + TMO) begin
            fin = 0;
            if (conv_done) begin
                m_bank[m_ch]  = conv_data;
                m_valid[m_ch] = 1;
                fin = 1;
            end else if (m_cyc == m_start_at + TMO) begin
                m_valid[m_ch] = 0;
                m_terr = 1;
                fin = 1;
            end
            if (fin) begin
                if (m_q.size() == 0) begin
                    nb = 0;
                    m_done_at  = m_cyc + 1;
                    m_start_at = -1;
                end else begin
                    m_ch = m_q.pop_front();
                    m_start_at = m_cyc + 2;
                end
            end
        end
        if (m_cyc % P == P - 1) begin
            if (m_busy) begin
                m_oerr = 1;
            end else if (chan_en != 8'd0) begin
                m_q.delete();
                for (int i = 0; i < 8; i++) if (chan_en[i]) m_q.push_back(i);
                m_ch = m_q.pop_front();
                m_start_at = m_cyc + 2;
                nb = 1;
            end
        end
        m_busy = nb;
        m_cyc++;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("conv_start",  conv_start,  exp_start);
            check("conv_addr",   conv_addr,   exp_addr);
            check("busy",        busy,        exp_busy);
            check("scan_done",   scan_done,   exp_scan);
            check("timeout_err", timeout_err, exp_terr);
            check("overrun_err", overrun_err, exp_oerr);
            check("rd_data",     rd_data,     exp_rdata);
            check("rd_valid",    rd_valid,    exp_rvalid);
        end
    end

    // ---------------- driver: SPI stand-in and stimulus ----------------
    int         abs_c = 0;
    bit         rst_req;
    bit         rand_mode;
    int         rd_fix;
    int         spi_delay;
    int         withhold;
    int         resp_at[$];
    logic [2:0] resp_addr[$];
    logic [2:0] start_log[$];
    int         start_cyc[$];
    int         n_scan;
    int         n_busy;

    task automatic do_cycle();
        bit hit;
        int dly;
        reset     = rst_req | (rand_mode && $urandom_range(0, 1499) == 0);
        conv_done = 1'b0;
        conv_data = 12'($urandom);
        hit = 0;
        for (int i = resp_at.size() - 1; i >= 0; i--) begin
            if (resp_at[i] == abs_c) begin
                if (!hit) begin
                    conv_done = 1'b1;
                    conv_data = 12'h100 + 12'(resp_addr[i]);
                    hit = 1;
                end
                resp_at.delete(i);
                resp_addr.delete(i);
            end
        end
        if (!hit && rand_mode && $urandom_range(0, 39) == 0) conv_done = 1'b1;
        rd_addr = (rd_fix >= 0) ? 3'(rd_fix) : 3'($urandom_range(0, 7));
        if (rand_mode && $urandom_range(0, 29) == 0) chan_en = 8'($urandom);
        #1;
        model_outputs();
        if (conv_start === 1'b1) begin
            start_log.push_back(conv_addr);
            start_cyc.push_back(m_cyc);
            if (rand_mode) dly = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(1, 20);
            else dly = spi_delay;
            if (int'(conv_addr) != withhold) begin
                resp_at.push_back(abs_c + dly);
                resp_addr.push_back(conv_addr);
            end
        end
        if (scan_done === 1'b1) n_scan++;
        if (busy === 1'b1) n_busy++;
        model_update();
        @(posedge clk);
        #1;
        abs_c++;
    endtask

    task automatic run(input int n);
        repeat (n) do_cycle();
    endtask

    task automatic apply_reset(input bit clear_spi);
        rst_req = 1;
        if (clear_spi) begin
            resp_at.delete();
            resp_addr.delete();
        end
        run(1);
        rst_req = 0;
        start_log.delete();
        start_cyc.delete();
        n_scan = 0;
        n_busy = 0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {conv_start, conv_addr, rd_data, rd_valid, scan_done, busy,
                     timeout_err, overrun_err}, 32'd0);
    endtask

    task automatic check_addrs(input string name);
        check({name, "_count"}, start_log.size(), exp_q.size());
        for (int i = 0; i < start_log.size() && exp_q.size() > 0; i++) begin
            check(name, start_log[i], exp_q.pop_front());
        end
        exp_q.delete();
    endtask

    // ---------------- main sequence and final report ----------------
    initial begin
        reset = 1'b1; chan_en = 8'h00; conv_done = 1'b0; conv_data = 12'h000; rd_addr = 3'd0;
        rst_req = 1; rand_mode = 0; rd_fix = -1; spi_delay = 10; withhold = -1;
        n_scan = 0; n_busy = 0;
        model_reset();
        @(posedge clk);
        #1;
        run(2);
        rst_req = 0;
        chk_on = 1;

        // 1: all channels, 10-cycle SPI
        chan_en = 8'hFF;
        start_log.delete(); start_cyc.delete(); n_scan = 0;
        check_all_zero("s1_reset_state");
        run(197);
        rd_fix = 5;
        run(2);
        rd_fix = -1;
        check("s1_rd5_data", rd_data, 12'h105);
        check("s1_rd5_valid", rd_valid, 1'b1);
        check("s1_first_start_cyc", (start_cyc.size() > 0) ? start_cyc[0] : -1, 101);
        check("s1_scan_done_count", n_scan, 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
        check_addrs("s1_addr_order");

        // 2: sparse mask
        apply_reset(1);
        chan_en = 8'h81;
        run(130);
        rd_fix = 7; run(1);
        check("s2_rd7_data", rd_data, 12'h107);
        check("s2_rd7_valid", rd_valid, 1'b1);
        rd_fix = 3; run(1);
        check("s2_rd3_data", rd_data, 12'h000);
        check("s2_rd3_valid", rd_valid, 1'b0);
        rd_fix = -1;
        exp_q.push_back(3'd0); exp_q.push_back(3'd7);
        check_addrs("s2_addr_order");

        // 3: nothing enabled
        apply_reset(1);
        chan_en = 8'h00;
        run(500);
        check("s3_starts", start_log.size(), 0);
        check("s3_scan_done", n_scan, 0);
        check("s3_busy_cycles", n_busy, 0);

        // 4: channel 2 never answers in the first round
        apply_reset(1);
        chan_en = 8'h07;
        withhold = 2;
        run(148);
        rd_fix = 2; run(2); rd_fix = -1;
        check("s4_rd2_valid_after_timeout", rd_valid, 1'b0);
        check("s4_timeout_err", timeout_err, 1'b1);
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        check_addrs("s4_addr_order");
        withhold = -1;
        run(99);
        rd_fix = 2; run(1); rd_fix = -1;
        check("s4_rd2_data_round2", rd_data, 12'h102);
        check("s4_rd2_valid_round2", rd_valid, 1'b1);

        // 4b: done on the last wait cycle beats the timeout
        apply_reset(1);
        chan_en = 8'h01;
        spi_delay = 16;
        run(130);
        rd_fix = 0; run(1); rd_fix = -1;
        check("s4b_timeout_err", timeout_err, 1'b0);
        check("s4b_rd0_data", rd_data, 12'h100);
        check("s4b_rd0_valid", rd_valid, 1'b1);

        // 5: slow SPI makes the round outlast the period
        apply_reset(1);
        chan_en = 8'hFF;
        spi_delay = 150;
        run(310);
        check("s5_overrun_err", overrun_err, 1'b1);
        check("s5_round2_start_cyc", (start_cyc.size() > 8) ? start_cyc[8] : -1, 301);
        check("s5_round2_first_addr", (start_log.size() > 8) ? start_log[8] : 3'd7, 3'd0);

        // 6: reset while waiting on channel 3; its late done must be ignored
        spi_delay = 10;
        apply_reset(1);
        chan_en = 8'hFF;
        run(140);
        check("s6_busy_before_reset", busy, 1'b1);
        check("s6_addr_before_reset", conv_addr, 3'd3);
        apply_reset(0);
        check_all_zero("s6_after_reset");
        run(12);
        for (int a = 0; a < 8; a++) begin
            rd_fix = a; run(1);
            check("s6_bank_cleared_data", rd_data, 12'h000);
            check("s6_bank_cleared_valid", rd_valid, 1'b0);
        end
        rd_fix = -1;

        // randomized phase
        rand_mode = 1;
        apply_reset(1);
        run(4000);
        rand_mode = 0;
        apply_reset(1);
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
